// File: rtl/rv32i_trace_monitor_pkg.sv
// Shared definitions for the rv32i commit-trace monitor: record layout, halt
// source encodings, status codes and the riscv-tests exit convention.
`timescale 1ns/1ps
package rv32i_trace_monitor_pkg;

    localparam int TRACE_W = 178;

    // Bit offsets of each field inside a packed trace record (LSB side first)
    localparam int OFF_PC       = 0;
    localparam int OFF_INST     = 32;
    localparam int OFF_RD_WR    = 64;
    localparam int OFF_RD_ADDR  = 65;
    localparam int OFF_RD_DATA  = 70;
    localparam int OFF_MEM_WR   = 102;
    localparam int OFF_MEM_ADDR = 103;
    localparam int OFF_MEM_DATA = 135;
    localparam int OFF_MEM_MASK = 167;
    localparam int OFF_CAUSE    = 171;
    localparam int OFF_TRAP     = 176;
    localparam int OFF_MRET     = 177;

    localparam int HALT_EBREAK_ECALL = 0;
    localparam int HALT_EBREAK_ONLY  = 1;
    localparam int HALT_ECALL_ONLY   = 2;
    localparam int HALT_ILLEGAL_PC   = 3;

    localparam logic [1:0] STATUS_UNKNOWN = 2'd0;
    localparam logic [1:0] STATUS_PASS    = 2'd1;
    localparam logic [1:0] STATUS_FAIL    = 2'd2;

    localparam logic [4:0]  EXIT_REG = 5'd17;
    localparam logic [31:0] EXIT_VAL = 32'h0000_005d;
    localparam logic [4:0]  CODE_REG = 5'd10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } mon_state_e;

    // First member lands at the MSB, matching the OFF_* offsets above
    typedef struct packed {
        logic        mret;
        logic        trap;
        logic [4:0]  cause;
        logic [3:0]  mem_mask;
        logic [31:0] mem_data;
        logic [31:0] mem_addr;
        logic        mem_wr;
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        rd_wr;
        logic [31:0] inst;
        logic [31:0] pc;
    } trace_rec_t;

endpackage

// File: rtl/rv32i_trace_monitor_trace_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_dout whenever
// o_empty is low. A push into a full FIFO is accepted only if a pop happens too.
`timescale 1ns/1ps
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (level_q == LW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);
    // Gate the head so an empty FIFO presents all zeros, including after reset
    assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

endmodule

// File: rtl/rv32i_trace_monitor.sv
// Commit-trace capture for the rv32i writeback stage: packs retired
// instructions into records, buffers them, and self-reports riscv-tests results.
`timescale 1ns/1ps
module rv32i_trace_monitor
    import rv32i_trace_monitor_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          HALT_MODE  = 0,
    parameter logic [31:0] PC_LIMIT   = 32'h0000_1FFC,
    parameter int          CNT_WIDTH  = 32,
    parameter int          DROP_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_commit,
    input  logic [31:0]               i_pc,
    input  logic [31:0]               i_inst,
    input  logic                      i_rd_wr,
    input  logic [4:0]                i_rd_addr,
    input  logic [31:0]               i_rd_data,
    input  logic                      i_mem_wr,
    input  logic [31:0]               i_mem_addr,
    input  logic [31:0]               i_mem_data,
    input  logic [3:0]                i_mem_mask,
    input  logic                      i_trap,
    input  logic [4:0]                i_trap_cause,
    input  logic                      i_mret,
    input  logic                      i_ebreak,
    input  logic                      i_ecall,
    input  logic                      i_illegal,
    input  logic                      i_clr,
    output logic                      o_trace_valid,
    input  logic                      i_trace_ready,
    output logic [TRACE_W-1:0]        o_trace_data,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_overflow,
    output logic [DROP_WIDTH-1:0]     o_drop_count,
    output logic [CNT_WIDTH-1:0]      o_commit_count,
    output logic                      o_halt,
    output logic [1:0]                o_status,
    output logic [1:0]                o_dbg_state
);

    mon_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  commit_cnt_q, commit_cnt_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           x10_q, x10_d;
    logic [31:0]           x17_q, x17_d;
    logic [1:0]            status_q, status_d;

    trace_rec_t rec;
    logic       accept;
    logic       halt_hit;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;

    assign accept = i_commit && (state_q == ST_RUN);
    // A full FIFO is never empty, so a ready consumer always frees a slot
    assign drop   = accept && fifo_full && !i_trace_ready;

    always_comb begin
        rec          = '0;
        rec.pc       = i_pc;
        rec.inst     = i_inst;
        rec.mret     = i_mret;
        if (i_rd_wr) begin
            rec.rd_wr   = 1'b1;
            rec.rd_addr = i_rd_addr;
            rec.rd_data = i_rd_data;
        end
        if (i_mem_wr) begin
            rec.mem_wr   = 1'b1;
            rec.mem_addr = i_mem_addr;
            rec.mem_data = i_mem_data;
            rec.mem_mask = i_mem_mask;
        end
        if (i_trap) begin
            rec.trap  = 1'b1;
            rec.cause = i_trap_cause;
        end
    end

    always_comb begin
        halt_hit = 1'b0;
        case (HALT_MODE)
            HALT_EBREAK_ECALL: halt_hit = i_ebreak || i_ecall;
            HALT_EBREAK_ONLY:  halt_hit = i_ebreak;
            HALT_ECALL_ONLY:   halt_hit = i_ecall;
            HALT_ILLEGAL_PC:   halt_hit = i_illegal || (i_pc >= PC_LIMIT);
            default:           halt_hit = 1'b0;
        endcase
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (accept),
        .i_din   (rec),
        .i_pop   (i_trace_ready),
        .o_dout  (o_trace_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    always_comb begin
        state_d      = state_q;
        commit_cnt_d = commit_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        x10_d        = x10_q;
        x17_d        = x17_q;
        status_d     = status_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    commit_cnt_d = commit_cnt_q + CNT_WIDTH'(1);
                    if (drop) begin
                        overflow_d = 1'b1;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
                        end
                    end
                    if (i_rd_wr && (i_rd_addr == CODE_REG)) begin
                        x10_d = i_rd_data;
                    end
                    if (i_rd_wr && (i_rd_addr == EXIT_REG)) begin
                        x17_d = i_rd_data;
                    end
                    if (halt_hit) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Shadows are frozen here, so the verdict is stable when latched
                if (fifo_empty) begin
                    state_d = ST_HALTED;
                    if (x17_q == EXIT_VAL) begin
                        status_d = (x10_q == '0) ? STATUS_PASS : STATUS_FAIL;
                    end else begin
                        status_d = STATUS_UNKNOWN;
                    end
                end
            end
            ST_HALTED: begin
                if (i_clr) begin
                    state_d      = ST_RUN;
                    commit_cnt_d = '0;
                    drop_cnt_d   = '0;
                    overflow_d   = 1'b0;
                    x10_d        = '0;
                    x17_d        = '0;
                    status_d     = STATUS_UNKNOWN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_RUN;
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            x10_q        <= '0;
            x17_q        <= '0;
            status_q     <= STATUS_UNKNOWN;
        end else begin
            state_q      <= state_d;
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            x10_q        <= x10_d;
            x17_q        <= x17_d;
            status_q     <= status_d;
        end
    end

    assign o_trace_valid  = !fifo_empty;
    assign o_overflow     = overflow_q;
    assign o_drop_count   = drop_cnt_q;
    assign o_commit_count = commit_cnt_q;
    assign o_halt         = (state_q == ST_HALTED);
    assign o_status       = status_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_rv32i_trace_monitor.sv
// Directed bench for rv32i_trace_monitor: one DEPTH=4 instance in halt mode 0
// and one in halt mode 3 with PC_LIMIT=0x100, sharing all inputs except commit.
`timescale 1ns/1ps
module tb_rv32i_trace_monitor;
    import rv32i_trace_monitor_pkg::*;

    localparam int W = TRACE_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          commit0, commit3;
    logic [31:0]   pc, inst, rd_data, mem_addr, mem_data;
    logic          rd_wr, mem_wr, trap, mret, ebreak, ecall, illegal, clr, ready;
    logic [4:0]    rd_addr, cause;
    logic [3:0]    mask;

    logic          v0, v3, ovf0, ovf3, halt0, halt3;
    logic [W-1:0]  data0, data3;
    logic [2:0]    level0, level3;
    logic [15:0]   drop0, drop3;
    logic [31:0]   cnt0, cnt3;
    logic [1:0]    status0, status3, dbg0, dbg3;

    logic [W-1:0]  exp0_q[$];
    logic [W-1:0]  exp3_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    rv32i_trace_monitor #(.DEPTH(4), .HALT_MODE(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_commit(commit0), .i_pc(pc), .i_inst(inst),
        .i_rd_wr(rd_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
        .i_mem_wr(mem_wr), .i_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_mask(mask),
        .i_trap(trap), .i_trap_cause(cause), .i_mret(mret), .i_ebreak(ebreak),
        .i_ecall(ecall), .i_illegal(illegal), .i_clr(clr),
        .o_trace_valid(v0), .i_trace_ready(ready), .o_trace_data(data0),
        .o_level(level0), .o_overflow(ovf0), .o_drop_count(drop0),
        .o_commit_count(cnt0), .o_halt(halt0), .o_status(status0), .o_dbg_state(dbg0)
    );

    rv32i_trace_monitor #(.DEPTH(4), .HALT_MODE(3), .PC_LIMIT(32'h100)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_commit(commit3), .i_pc(pc), .i_inst(inst),
        .i_rd_wr(rd_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
        .i_mem_wr(mem_wr), .i_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_mask(mask),
        .i_trap(trap), .i_trap_cause(cause), .i_mret(mret), .i_ebreak(ebreak),
        .i_ecall(ecall), .i_illegal(illegal), .i_clr(clr),
        .o_trace_valid(v3), .i_trace_ready(ready), .o_trace_data(data3),
        .o_level(level3), .o_overflow(ovf3), .o_drop_count(drop3),
        .o_commit_count(cnt3), .o_halt(halt3), .o_status(status3), .o_dbg_state(dbg3)
    );

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected record built from the bench's own view of the commit inputs
    function automatic logic [W-1:0] model();
        return {mret, trap, trap ? cause : 5'd0,
                mem_wr ? mask : 4'd0, mem_wr ? mem_data : 32'd0, mem_wr ? mem_addr : 32'd0, mem_wr,
                rd_wr ? rd_data : 32'd0, rd_wr ? rd_addr : 5'd0, rd_wr, inst, pc};
    endfunction

    task automatic idle_inputs();
        commit0 = 0; commit3 = 0; pc = 0; inst = 32'h0000_0013;
        rd_wr = 0; rd_addr = 0; rd_data = 0; mem_wr = 0; mem_addr = 0; mem_data = 0; mask = 0;
        trap = 0; cause = 0; mret = 0; ebreak = 0; ecall = 0; illegal = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_rec(input bit sel3, input bit pushed);
        if (pushed) begin
            if (sel3) exp3_q.push_back(model());
            else      exp0_q.push_back(model());
        end
        if (sel3) commit3 = 1;
        else      commit0 = 1;
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 0; ready = 0; rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        exp0_q.delete();
        exp3_q.delete();
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic wait_halt(input bit sel3, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (sel3 ? halt3 : halt0) break;
            tick();
        end
        chk(tag, sel3 ? halt3 : halt0, 1);
    endtask

    // Scoreboards: a head accepted at the next edge must match the queue front
    always @(negedge clk) begin
        if (rst_n && v0 && ready)
            chk("rec0", data0, (exp0_q.size() > 0) ? exp0_q.pop_front() : {W{1'b1}});
        if (rst_n && v3 && ready)
            chk("rec3", data3, (exp3_q.size() > 0) ? exp3_q.pop_front() : {W{1'b1}});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_valid", v0, 0);
        chk("rst_data", data0, 0);
        chk("rst_level", level0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_halt", halt0, 0);
        chk("rst_status", status0, 0);
        chk("rst_state", dbg0, ST_RUN);

        // Three in-order records, the second writing x5 = 0x11
        ready = 1;
        pc = 32'h0; commit_rec(0, 1);
        pc = 32'h4; inst = 32'h0110_0293; rd_wr = 1; rd_addr = 5; rd_data = 32'h11; commit_rec(0, 1);
        pc = 32'h8; commit_rec(0, 1);
        repeat (3) tick();
        chk("t1_cnt", cnt0, 3);
        chk("t1_level", level0, 0);
        chk("t1_sb_empty", exp0_q.size(), 0);

        // Overflow: 6 commits into 4 entries, then simultaneous push and pop when full
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pc = 32'h10 + 32'(4 * i);
            commit_rec(0, i < 4);
        end
        chk("t2_level", level0, 4);
        chk("t2_drop", drop0, 2);
        chk("t2_ovf", ovf0, 1);
        chk("t2_head_pc", data0[31:0], 32'h10);
        pc = 32'h28; ready = 1;
        commit_rec(0, 1);
        chk("t3_level", level0, 4);
        chk("t3_drop", drop0, 2);
        chk("t3_cnt", cnt0, 7);
        repeat (6) tick();
        chk("t3_level_drained", level0, 0);
        chk("t3_sb_empty", exp0_q.size(), 0);

        // Mode 0: pass verdict via ebreak
        do_reset();
        ready = 1;
        pc = 32'h0; rd_wr = 1; rd_addr = 17; rd_data = 32'h5d; commit_rec(0, 1);
        pc = 32'h4; rd_wr = 1; rd_addr = 10; rd_data = 32'h0; commit_rec(0, 1);
        pc = 32'h8; inst = 32'h0010_0073; ebreak = 1; commit_rec(0, 1);
        chk("t4_state_drain", dbg0, ST_DRAIN);
        chk("t4_halt_in_drain", halt0, 0);
        wait_halt(0, "t4_halt");
        chk("t4_status", status0, STATUS_PASS);
        chk("t4_cnt", cnt0, 3);
        chk("t4_sb_empty", exp0_q.size(), 0);
        pulse_clr();
        chk("t4_clr_halt", halt0, 0);
        chk("t4_clr_status", status0, 0);
        chk("t4_clr_cnt", cnt0, 0);
        chk("t4_clr_state", dbg0, ST_RUN);

        // Mode 0: fail verdict, and a commit during DRAIN is ignored
        ready = 0;
        pc = 32'h0; rd_wr = 1; rd_addr = 17; rd_data = 32'h5d; commit_rec(0, 1);
        pc = 32'h4; rd_wr = 1; rd_addr = 10; rd_data = 32'h6; commit_rec(0, 1);
        pc = 32'h8; inst = 32'h0010_0073; ebreak = 1; commit_rec(0, 1);
        chk("t5_state_drain", dbg0, ST_DRAIN);
        chk("t5_level", level0, 3);
        pc = 32'hC; rd_wr = 1; rd_addr = 10; rd_data = 32'h0; commit_rec(0, 0);
        chk("t5_drain_level", level0, 3);
        chk("t5_drain_cnt", cnt0, 3);
        ready = 1;
        wait_halt(0, "t5_halt");
        chk("t5_status", status0, STATUS_FAIL);
        chk("t5_sb_empty", exp0_q.size(), 0);

        // Mode 3: pc 0xFC stays below the limit, pc 0x100 halts while full (dropped)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pc = 32'(4 * i);
            commit_rec(1, 1);
        end
        pc = 32'hFC;  commit_rec(1, 0);
        pc = 32'h100; commit_rec(1, 0);
        chk("t6_state_drain", dbg3, ST_DRAIN);
        chk("t6_drop", drop3, 2);
        chk("t6_ovf", ovf3, 1);
        chk("t6_level", level3, 4);
        chk("t6_cnt", cnt3, 6);
        ready = 1;
        wait_halt(1, "t6_halt");
        chk("t6_status", status3, STATUS_UNKNOWN);
        chk("t6_sb_empty", exp3_q.size(), 0);
        pulse_clr();
        chk("t6_clr_halt", halt3, 0);
        chk("t6_clr_cnt", cnt3, 0);
        chk("t6_clr_ovf", ovf3, 0);
        chk("t6_clr_drop", drop3, 0);
        chk("t6_clr_status", status3, 0);
        chk("t6_clr_state", dbg3, ST_RUN);

        // Field packing of a trap record with a byte store; rd fields must be zeroed
        do_reset();
        pc = 32'h200; inst = 32'h1234_5678; trap = 1; cause = 5'h1B;
        mem_wr = 1; mem_addr = 32'h1080; mem_data = 32'hAB; mask = 4'b0001;
        rd_wr = 0; rd_addr = 7; rd_data = 32'hDEAD;
        commit_rec(0, 1);
        chk("pk_pc", data0[31:0], 32'h200);
        chk("pk_inst", data0[63:32], 32'h1234_5678);
        chk("pk_rd_wr", data0[64], 0);
        chk("pk_rd_addr", data0[69:65], 0);
        chk("pk_rd_data", data0[101:70], 0);
        chk("pk_mem_wr", data0[102], 1);
        chk("pk_mem_addr", data0[134:103], 32'h1080);
        chk("pk_mem_data", data0[166:135], 32'hAB);
        chk("pk_mem_mask", data0[170:167], 4'b0001);
        chk("pk_cause", data0[175:171], 5'h1B);
        chk("pk_trap", data0[176], 1);
        chk("pk_mret", data0[177], 0);
        pc = 32'h204; trap = 0; cause = 5'h1F; mret = 1;
        mem_wr = 0; mem_addr = 32'h55; mem_data = 32'h66; mask = 4'hF;
        rd_wr = 1; rd_addr = 1; rd_data = 32'h77;
        commit_rec(0, 1);
        pc = 32'h208; inst = 32'h0010_0073; ebreak = 1; commit_rec(0, 1);
        chk("t7_state_drain", dbg0, ST_DRAIN);
        ready = 1;
        repeat (2) tick();
        ready = 0;
        chk("t7_level", level0, 1);
        chk("t7_still_drain", dbg0, ST_DRAIN);

        // Asynchronous reset mid-drain, checked before any clock edge
        #3;
        rst_n = 0;
        #1;
        chk("ar_valid", v0, 0);
        chk("ar_data", data0, 0);
        chk("ar_level", level0, 0);
        chk("ar_ovf", ovf0, 0);
        chk("ar_drop", drop0, 0);
        chk("ar_cnt", cnt0, 0);
        chk("ar_halt", halt0, 0);
        chk("ar_status", status0, 0);
        chk("ar_state", dbg0, ST_RUN);
        exp0_q.delete();
        tick();
        rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_trace_monitor.md
Name: rv32i_trace_monitor

Overview:
- Synthesizable commit-trace capture unit attached to the rv32i core writeback stage.
- Packs each retired instruction into a record: PC, instruction, base-register write, data-memory write, trap/mret info. Records are buffered in a DEPTH-entry FIFO and drained over valid/ready by a debug/UART bridge.
- Adds a parametrised halt-detect FSM and riscv-tests pass/fail evaluation (x17 == 0x5d, x10 == 0), so on-chip runs self-report without a simulator.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- HALT_MODE, 0, halt source: 0 = ebreak|ecall, 1 = ebreak only, 2 = ecall only, 3 = illegal instruction or PC >= PC_LIMIT.
- PC_LIMIT, 32'h0000_1FFC, PC bound used only in HALT_MODE 3.
- CNT_WIDTH, 32, width of the commit counter.
- DROP_WIDTH, 16, width of the drop counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_commit  in  1  instruction retires this cycle (core asserts writeback_ce && !stall[WRITEBACK])
- i_pc  in  32  PC of the retiring instruction
- i_inst  in  32  instruction word
- i_rd_wr  in  1  base-register write
- i_rd_addr  in  5  destination register
- i_rd_data  in  32  write value
- i_mem_wr  in  1  data-memory write
- i_mem_addr  in  32  memory address
- i_mem_data  in  32  memory data
- i_mem_mask  in  4  byte mask
- i_trap  in  1  go-to-trap
- i_trap_cause  in  5  {mcause_intbit, mcause_code}
- i_mret  in  1  return from trap
- i_ebreak  in  1  ebreak retiring
- i_ecall  in  1  ecall retiring
- i_illegal  in  1  illegal instruction retiring
- i_clr  in  1  restart monitor from HALTED
- o_trace_valid  out  1  FIFO head valid
- i_trace_ready  in  1  consumer accepts head
- o_trace_data  out  TRACE_W (178)  head record
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: a record was dropped
- o_drop_count  out  DROP_WIDTH  dropped records, saturating
- o_commit_count  out  CNT_WIDTH  commits seen while RUN
- o_halt  out  1  state == HALTED
- o_status  out  2  0 = unknown, 1 = pass, 2 = fail; valid only while o_halt

Behaviour:
- Every input except i_trace_ready and i_clr is sampled only when i_commit = 1 and state is RUN.
- Record field order, MSB to LSB: mret, trap, cause[4:0], mem_mask, mem_data, mem_addr, mem_wr, rd_data, rd_addr, rd_wr, inst, pc.
  - When rd_wr = 0, rd fields are zeroed.
  - When mem_wr = 0, mem fields are zeroed.
  - When trap = 0, cause is zeroed.
- FIFO:
  - Push on an accepted commit; pop on o_trace_valid && i_trace_ready.
  - o_trace_data is show-ahead (head entry read combinationally).
  - Latency: a commit sampled at edge N has o_trace_valid = 1 after edge N.
  - Full and push, no pop: record dropped, o_overflow set, o_drop_count incremented (saturates at all ones).
  - Full and push with a simultaneous pop: push accepted, no drop.
  - Empty: o_trace_valid = 0 and ready is ignored. Pointers wrap modulo DEPTH.
- Shadow registers x10_s and x17_s (32 bits each) update on any accepted commit with rd_wr && rd_addr == 10 or rd_addr == 17.
- Halt condition is evaluated on an accepted commit per HALT_MODE. In mode 3 the condition is i_illegal || i_pc >= PC_LIMIT.
- FSM:
  - RUN: accept commits and increment o_commit_count. On a halt condition the halting record is still pushed and counted; go to DRAIN.
  - DRAIN: ignore commits (not pushed, not counted); wait for o_level == 0, then go to HALTED.
  - HALTED: o_halt = 1; o_status is latched on entry: 1 if x17_s == 0x5d && x10_s == 0, 2 if x17_s == 0x5d && x10_s != 0, else 0.
  - HALTED with i_clr = 1: go to RUN. This clears the counters, o_overflow, shadows and o_status. FIFO is already empty.
  - i_clr is ignored in RUN and DRAIN.
- Reset (asynchronous, any time, including mid-drain):
  - State RUN, FIFO empty, all counters and shadows 0.
  - All outputs 0: o_trace_valid, o_trace_data, o_level, o_overflow, o_drop_count, o_commit_count, o_halt, o_status.
- A halt condition while the FIFO is full and not popping: the halting record is dropped, but the FSM still enters DRAIN.

Decomposition:
- Shared header rv32i_header.vh gains:
  - Record field offsets and TRACE_W.
  - HALT_MODE encodings.
  - Status codes.
  - Exit constants EXIT_REG = 17, EXIT_VAL = 32'h5d, CODE_REG = 10.
- One sub-module: trace_fifo (parametrised WIDTH/DEPTH show-ahead synchronous FIFO providing full, empty and level). The FSM, packing, counters and shadows stay in the top.

Test Plan:
- 3 commits (pc 0x0/0x4/0x8; rd x5 = 0x11 on the second), ready = 1 → 3 records in order, the second with rd_wr = 1, addr 5, data 0x11; o_commit_count = 3.
- DEPTH = 4, ready = 0, 6 commits → o_level = 4, o_drop_count = 2, o_overflow = 1; then ready = 1 → the first 4 PCs drain in order.
- Full FIFO, push and pop in the same cycle → o_level stays 4, o_drop_count unchanged.
- HALT_MODE 0: write x17 = 0x5d and x10 = 0, then ebreak commit, ready = 1 → ebreak record emitted, DRAIN → HALTED, o_status = 1. Repeat with x10 = 6 → o_status = 2; a commit during DRAIN is not emitted.
- HALT_MODE 3, PC_LIMIT = 0x100: commit pc 0x100 → halt. Then i_clr → RUN, with counters, o_overflow and o_status at 0.
- Trap commit with cause {1, 4'd11} and a memory write 0x1080/0xAB/4'b0001 → fields packed exactly. Assert i_rst_n low mid-DRAIN → all outputs 0 immediately, with no clock edge.
